// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display path: BCD width and active-low
// 7-segment patterns in {g,f,e,d,c,b,a} order.
package clock_disp_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// Multiplexed common-anode 7-segment scanner with per-frame input snapshot,
// per-digit blink and decimal point, and leading-zero blanking.
module disp_scan
  import clock_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]       blink_mask_i,
  input  logic [NUM_DIGITS-1:0]       dp_mask_i,
  input  logic                        blank_lead_i,
  output logic [6:0]                  seg_o,
  output logic                        dp_o,
  output logic [NUM_DIGITS-1:0]       an_o,
  output logic                        frame_o
);

  localparam int PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]                 presc;
  logic [IW-1:0]                 idx;
  logic [FW-1:0]                 frame_cnt;
  logic                          blink_phase;
  logic                          primed;
  logic [BCD_W*NUM_DIGITS-1:0]   snap_digits;
  logic [NUM_DIGITS-1:0]         snap_blink;
  logic [NUM_DIGITS-1:0]         snap_dp;
  logic                          snap_lead;

  logic                  tick, last, load, blank;
  logic [BCD_W-1:0]      cur_digit;
  logic                  cur_blink, cur_dp;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [6:0]            seg_dec;

  assign tick = (presc == PW'(SCAN_DIV - 1));
  assign last = (idx == IW'(NUM_DIGITS - 1));
  // Inputs are only captured at a frame boundary so a carry can never tear.
  assign load = !primed || (tick && last);

  always_comb begin
    cur_digit = '0;
    cur_blink = 1'b0;
    cur_dp    = 1'b0;
    an_sel    = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_digit = snap_digits[k*BCD_W +: BCD_W];
        cur_blink = snap_blink[k];
        cur_dp    = snap_dp[k];
        an_sel[k] = 1'b0;
      end
    end
  end

  assign blank = !primed
              || (presc < PW'(DEAD_CYCLES))
              || (blink_phase && cur_blink)
              || (snap_lead && last && (cur_digit == '0));

  seg7_decode u_dec (
    .bcd (cur_digit),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      primed      <= 1'b0;
      snap_digits <= '0;
      snap_blink  <= '0;
      snap_dp     <= '0;
      snap_lead   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) idx <= last ? '0 : idx + IW'(1);
      primed <= 1'b1;
      if (load) begin
        snap_digits <= digits_i;
        snap_blink  <= blink_mask_i;
        snap_dp     <= dp_mask_i;
        snap_lead   <= blank_lead_i;
      end
      // The priming load does not count as a completed frame.
      if (load && primed) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o   <= SEG_OFF;
      dp_o    <= 1'b1;
      an_o    <= '1;
      frame_o <= 1'b0;
    end else begin
      frame_o <= load;
      if (blank) begin
        seg_o <= SEG_OFF;
        dp_o  <= 1'b1;
        an_o  <= '1;
      end else begin
        seg_o <= seg_dec;
        dp_o  <= ~cur_dp;
        an_o  <= an_sel;
      end
    end
  end

endmodule
